// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//   Command-decoding byte memory that sits behind an SPI slave. Each 10-bit
//   word from the slave carries a 2-bit command in [9:8] and a byte payload in
//   [7:0]:
//     00 : load write address        01 : write payload to mem[wr_addr]
//     10 : load read address         11 : read mem[rd_addr] onto tx_data
//   Data commands issued before their address has ever been loaded are
//   dropped and raise the sticky err flag.
//
// Handshake:
//   rx_valid is a level from the slave with no ready/backpressure. A command
//   is accepted only on the first cycle rx_valid is seen high (rx_valid rising
//   edge), so a level held for many cycles acts once. rx_data is sampled in
//   that accept cycle only. tx_valid is a level with no ready: it rises one
//   cycle after an accepted, successful read and holds until the next
//   accepted command of any type.
//
// Optional build macro:
//   SPI_RAM_ADDR_AUTO_INC_EN - successful data commands post-increment their
//   address register (wrapping MEM_DEPTH-1 -> 0).
//
// Ports:
//   clk      in   1   rising-edge system clock
//   rst_n    in   1   asynchronous active-low reset
//   rx_data  in  10   [9:8] cmd, [7:0] payload
//   rx_valid in   1   rx_data valid (level)
//   tx_data  out  8   read data for the slave
//   tx_valid out  1   tx_data valid for shifting out
//   err      out  1   sticky protocol-error flag
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       err
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [7:0]           r_mem [MEM_DEPTH];
  logic                 r_rx_valid_d;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_wa_ok;
  logic                 r_ra_ok;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_err;

  logic                 w_accept;
  logic [1:0]           w_cmd;
  logic [7:0]           w_payload;
  logic                 w_wr_go;

  assign w_accept  = rx_valid & ~r_rx_valid_d;
  assign w_cmd     = rx_data[9:8];
  assign w_payload = rx_data[7:0];
  assign w_wr_go   = w_accept && (w_cmd == CMD_WR_DATA) && r_wa_ok;

  // Storage is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_go) begin
      r_mem[r_wr_addr] <= w_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid_d <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_wa_ok      <= 1'b0;
      r_ra_ok      <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rx_valid_d <= rx_valid;
      if (w_accept) begin
        // Any accepted command retires the previous read result; a successful
        // read below re-asserts it on the same edge.
        r_tx_valid <= 1'b0;
        case (w_cmd)
          CMD_WR_ADDR: begin
            r_wr_addr <= w_payload[ADDR_SIZE-1:0];
            r_wa_ok   <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (r_wa_ok) begin
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
              r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
          CMD_RD_ADDR: begin
            r_rd_addr <= w_payload[ADDR_SIZE-1:0];
            r_ra_ok   <= 1'b1;
          end
          CMD_RD_DATA: begin
            if (r_ra_ok) begin
              r_tx_data  <= r_mem[r_rd_addr];
              r_tx_valid <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
              // tx_data above uses the pre-increment address.
              r_rd_addr  <= r_rd_addr + ADDR_SIZE'(1);
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign err      = r_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_ctrl
//   Directed stimulus with hand-computed expectations. Each command pushes the
//   expected {tx_valid, tx_data, err} seen one cycle after its accept; a
//   monitor tracks accepts (rx_valid rising edge) and pops/compares.
// -----------------------------------------------------------------------------
module tb_spi_ram_ctrl;

  typedef struct packed {
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       err;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  logic tb_rv_d;

  spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .err      (err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // driver: one pulse of rx_valid, held for 'hold' cycles
  task automatic send(input logic [9:0] word, input int hold, input exp_t e);
    @(negedge clk);
    rx_data  = word;
    rx_valid = 1'b1;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic exp_t mk(logic v, logic [7:0] d, logic e);
    exp_t x;
    x.tx_valid = v;
    x.tx_data  = d;
    x.err      = e;
    return x;
  endfunction

  // monitor / scoreboard: compare one cycle after every accept
  always @(negedge rst_n) tb_rv_d = 1'b0;

  initial begin
    logic acc;
    exp_t e;
    tb_rv_d = 1'b0;
    forever begin
      @(posedge clk);
      acc     = rst_n && rx_valid && !tb_rv_d;
      tb_rv_d = rst_n ? rx_valid : 1'b0;
      @(negedge clk);
      if (acc) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got accept, expected none");
        end else begin
          e = exp_q.pop_front();
          check("sb_tx_valid", 32'(tx_valid), 32'(e.tx_valid));
          check("sb_tx_data",  32'(tx_data),  32'(e.tx_data));
          check("sb_err",      32'(err),      32'(e.err));
        end
      end
    end
  end

  initial begin
    int idle_bad;
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    rx_data  = 10'h000;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_err",      32'(err),      32'd0);
    rst_n = 1'b1;

    // basic write then read
    send(10'h005, 1, mk(1'b0, 8'h00, 1'b0));
    send(10'h1A5, 1, mk(1'b0, 8'h00, 1'b0));
    send(10'h205, 1, mk(1'b0, 8'h00, 1'b0));
    send(10'h300, 1, mk(1'b1, 8'hA5, 1'b0));

    // tx_valid holds through idle, clears on next accept
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5) idle_bad++;
    end
    check("idle_hold_bad_cycles", 32'(idle_bad), 32'd0);
    send(10'h207, 1, mk(1'b0, 8'hA5, 1'b0));

    // held rx_valid acts once; payload change while held is ignored
    send(10'h010, 1, mk(1'b0, 8'hA5, 1'b0));
    @(negedge clk);
    rx_data  = 10'h13C;
    rx_valid = 1'b1;
    exp_q.push_back(mk(1'b0, 8'hA5, 1'b0));
    repeat (5) @(negedge clk);
    rx_data = 10'h177;
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    send(10'h210, 1, mk(1'b0, 8'hA5, 1'b0));
    send(10'h300, 1, mk(1'b1, 8'h3C, 1'b0));

    // known value at address 0 so a dropped write after reset is observable
    send(10'h000, 1, mk(1'b0, 8'h3C, 1'b0));
    send(10'h1C3, 1, mk(1'b0, 8'h3C, 1'b0));
    send(10'h210, 1, mk(1'b0, 8'h3C, 1'b0));
    send(10'h300, 1, mk(1'b1, 8'h3C, 1'b0));
    check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);

    // async reset mid-cycle while tx_valid=1
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx_valid", 32'(tx_valid), 32'd0);
    check("async_tx_data",  32'(tx_data),  32'd0);
    check("async_err",      32'(err),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // protocol errors from reset: read and write without addresses
    send(10'h300, 1, mk(1'b0, 8'h00, 1'b1));
    send(10'h1FF, 1, mk(1'b0, 8'h00, 1'b1));
    // memory survived reset and the failed write did not land at addr 0
    send(10'h000, 1, mk(1'b0, 8'h00, 1'b1));
    send(10'h200, 1, mk(1'b0, 8'h00, 1'b1));
    send(10'h300, 1, mk(1'b1, 8'hC3, 1'b1));
    send(10'h205, 1, mk(1'b0, 8'hC3, 1'b1));
    send(10'h300, 1, mk(1'b1, 8'hA5, 1'b1));

`ifdef SPI_RAM_ADDR_AUTO_INC_EN
    send(10'h0FF, 1, mk(1'b0, 8'hA5, 1'b1));
    send(10'h111, 1, mk(1'b0, 8'hA5, 1'b1));
    send(10'h122, 1, mk(1'b0, 8'hA5, 1'b1));
    send(10'h2FF, 1, mk(1'b0, 8'hA5, 1'b1));
    send(10'h300, 1, mk(1'b1, 8'h11, 1'b1));
    send(10'h300, 1, mk(1'b1, 8'h22, 1'b1));
`endif

    repeat (3) @(negedge clk);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
